// File: rtl/aes_wb_stream_ctrl.sv
// aes_wb_stream_ctrl
//   Wishbone slave that feeds a fixed-latency AES core. Software loads KEY
//   and DIN, issues GO, and collects results from a small FIFO through DOUT.
//   A token shift register tracks each block through the core.
//
// Ports
//   wb_clk_i      clock (also clocks the attached core)
//   wb_rst_i      synchronous active-low reset
//   wb_dat_i/o    WB write / registered read data
//   wb_adr_i      byte address, word index = adr[7:2]
//   wb_sel_i      byte enables (KEY/DIN writes only)
//   wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o   WB handshake
//   core_state_o  plaintext held for the core from the cycle after GO
//   core_key_o    KEY register
//   core_out_i    core ciphertext, sampled when a token leaves the pipe
//   irq_o         IE & result available (registered)
//
// Map (word 0 = MSBs): 0x00 KEY, 0x10 DIN, 0x20 DOUT (0x2C pops),
//   0x30 CTRL {IE,FLUSH,GO}, 0x34 STATUS {key_err,unf,ovf,busy,in_flight,out_count}
module aes_wb_stream_ctrl #(
  parameter int           DEPTH   = 4,
  parameter int           LATENCY = 21,
  parameter logic [127:0] KEY_RST = 128'h0
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic [31:0]  wb_dat_i,
  output logic [31:0]  wb_dat_o,
  input  logic [7:0]   wb_adr_i,
  input  logic [3:0]   wb_sel_i,
  input  logic         wb_we_i,
  input  logic         wb_cyc_i,
  input  logic         wb_stb_i,
  output logic         wb_ack_o,
  output logic [127:0] core_state_o,
  output logic [127:0] core_key_o,
  input  logic [127:0] core_out_i,
  output logic         irq_o
);
  localparam int PW = $clog2(DEPTH);

  logic [127:0]       r_key, r_din, r_state;
  logic               r_ie, r_ack, r_irq, r_issue, r_ovf, r_unf, r_kerr;
  logic [31:0]        r_dat;
  logic [LATENCY-1:0] r_tok;
  logic [127:0]       r_mem [DEPTH];
  logic [PW-1:0]      r_wptr, r_rptr;
  logic [4:0]         r_out_cnt;
  logic [5:0]         r_in_flight;

  logic        w_req, w_wr, w_rd;
  logic [5:0]  w_word;
  logic [6:0]  w_lsb;
  logic        w_key_sel, w_din_sel, w_dout_sel, w_ctrl_sel, w_stat_sel;
  logic        w_busy, w_empty, w_flush, w_go, w_room, w_accept, w_cap, w_pop;
  logic        w_unf_set, w_kerr_set, w_ovf_set, w_stat_wr, w_ie_next, w_mem_we;
  logic [127:0] w_head;
  logic [31:0] w_rdata;
  logic [4:0]  w_out_cnt_next;
  logic [5:0]  w_in_flight_next;
  logic [LATENCY-1:0] w_tok_shift;
  logic        w_unused_adr;

  function automatic logic [31:0] f_merge(input logic [31:0] old_w,
                                          input logic [31:0] new_w,
                                          input logic [3:0]  sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[8*b +: 8] = sel[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    return res;
  endfunction

  // Single-cycle ack: a new request is only seen while ack is low.
  assign w_req  = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_wr   = w_req & wb_we_i;
  assign w_rd   = w_req & ~wb_we_i;
  assign w_word = wb_adr_i[7:2];
  assign w_unused_adr = ^wb_adr_i[1:0];
  // Word 0 of each 128-bit register carries bits [127:96].
  assign w_lsb  = {2'd3 - wb_adr_i[3:2], 5'd0};

  assign w_key_sel  = (w_word[5:2] == 4'd0);
  assign w_din_sel  = (w_word[5:2] == 4'd1);
  assign w_dout_sel = (w_word[5:2] == 4'd2);
  assign w_ctrl_sel = (w_word == 6'd12);
  assign w_stat_sel = (w_word == 6'd13);

  assign w_busy     = (r_in_flight != 6'd0);
  assign w_empty    = (r_out_cnt == 5'd0);
  assign w_stat_wr  = w_wr & w_stat_sel;
  // FLUSH dominates GO in the same write.
  assign w_flush    = w_wr & w_ctrl_sel & wb_dat_i[1];
  assign w_go       = w_wr & w_ctrl_sel & wb_dat_i[0] & ~wb_dat_i[1];
  // Reserve a FIFO slot for every block still in the core.
  assign w_room     = ({1'b0, r_in_flight} + {2'b00, r_out_cnt}) < 7'(DEPTH);
  assign w_accept   = w_go & w_room;
  assign w_ovf_set  = w_go & ~w_room;
  assign w_cap      = r_tok[LATENCY-1] & ~w_flush;
  assign w_pop      = w_rd & w_dout_sel & (w_word[1:0] == 2'd3) & ~w_empty;
  assign w_unf_set  = w_rd & w_dout_sel & w_empty;
  assign w_kerr_set = w_wr & w_key_sel & w_busy;
  assign w_head     = r_mem[r_rptr];
  assign w_mem_we   = w_cap & wb_rst_i;

  // The issue flop aligns the token with the core's first sample of core_state_o.
  generate
    if (LATENCY > 1) begin : g_tok
      assign w_tok_shift = {r_tok[LATENCY-2:0], r_issue};
    end else begin : g_tok1
      assign w_tok_shift = r_issue;
    end
  endgenerate

  always_comb begin
    w_out_cnt_next   = r_out_cnt + {4'd0, w_cap} - {4'd0, w_pop};
    w_in_flight_next = r_in_flight + {5'd0, w_accept} - {5'd0, w_cap};
    if (w_flush) begin
      w_out_cnt_next   = 5'd0;
      w_in_flight_next = 6'd0;
    end
    w_ie_next = (w_wr & w_ctrl_sel) ? wb_dat_i[2] : r_ie;
  end

  always_comb begin
    w_rdata = 32'd0;
    if (w_key_sel)       w_rdata = r_key[w_lsb +: 32];
    else if (w_din_sel)  w_rdata = r_din[w_lsb +: 32];
    else if (w_dout_sel) w_rdata = w_empty ? 32'd0 : w_head[w_lsb +: 32];
    else if (w_ctrl_sel) w_rdata = {29'd0, r_ie, 2'b00};
    else if (w_stat_sel) w_rdata = {17'd0, r_kerr, r_unf, r_ovf, w_busy, r_in_flight, r_out_cnt};
  end

  always_ff @(posedge wb_clk_i) begin
    if (w_mem_we) r_mem[r_wptr] <= core_out_i;
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      r_key       <= KEY_RST;
      r_din       <= '0;
      r_state     <= '0;
      r_ie        <= 1'b0;
      r_ack       <= 1'b0;
      r_dat       <= '0;
      r_irq       <= 1'b0;
      r_issue     <= 1'b0;
      r_tok       <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_out_cnt   <= '0;
      r_in_flight <= '0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_kerr      <= 1'b0;
    end else begin
      r_ack <= w_req;
      r_dat <= w_rd ? w_rdata : 32'd0;
      if (w_wr & w_key_sel & ~w_busy)
        r_key[w_lsb +: 32] <= f_merge(r_key[w_lsb +: 32], wb_dat_i, wb_sel_i);
      if (w_wr & w_din_sel)
        r_din[w_lsb +: 32] <= f_merge(r_din[w_lsb +: 32], wb_dat_i, wb_sel_i);
      r_ie <= w_ie_next;
      if (w_accept) r_state <= r_din;
      if (w_flush) begin
        r_issue <= 1'b0;
        r_tok   <= '0;
        r_wptr  <= '0;
        r_rptr  <= '0;
      end else begin
        r_issue <= w_accept;
        r_tok   <= w_tok_shift;
        if (w_cap) r_wptr <= r_wptr + 1'b1;
        if (w_pop) r_rptr <= r_rptr + 1'b1;
      end
      r_out_cnt   <= w_out_cnt_next;
      r_in_flight <= w_in_flight_next;
      // W1C clear first; a set event in the same cycle wins.
      r_ovf  <= (r_ovf  & ~(w_stat_wr & wb_dat_i[12])) | w_ovf_set;
      r_unf  <= (r_unf  & ~(w_stat_wr & wb_dat_i[13])) | w_unf_set;
      r_kerr <= (r_kerr & ~(w_stat_wr & wb_dat_i[14])) | w_kerr_set;
      r_irq  <= w_ie_next & (w_out_cnt_next != 5'd0);
    end
  end

  assign wb_ack_o     = r_ack;
  assign wb_dat_o     = r_dat;
  assign irq_o        = r_irq;
  assign core_state_o = r_state;
  assign core_key_o   = r_key;
endmodule

// File: tb/tb_aes_wb_stream_ctrl.sv
// Testbench for aes_wb_stream_ctrl: an XOR core stub, a queue-based model of
// the register map / FIFO checked every cycle, and directed register accesses
// with hand-computed expectations.
module tb_aes_wb_stream_ctrl;
  localparam int           DEPTH = 4;
  localparam int           LAT   = 21;
  localparam logic [127:0] KRST  = 128'h0f0e0d0c_0b0a0908_07060504_03020100;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  dat_i = '0, dat_o;
  logic [7:0]   adr = '0;
  logic [3:0]   sel = 4'hf;
  logic         we = 1'b0, cyc = 1'b0, stb = 1'b0, ack, irq;
  logic [127:0] core_state, core_key, core_out;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  aes_wb_stream_ctrl #(.DEPTH(DEPTH), .LATENCY(LAT), .KEY_RST(KRST)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_dat_i(dat_i), .wb_dat_o(dat_o),
    .wb_adr_i(adr), .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb),
    .wb_ack_o(ack), .core_state_o(core_state), .core_key_o(core_key),
    .core_out_i(core_out), .irq_o(irq)
  );

  // Core stub: out = state ^ key, delayed LAT cycles.
  logic [127:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= core_state ^ core_key;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign core_out = pipe[LAT-1];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int due; logic [127:0] val; } blk_t;
  blk_t         pend[$];
  logic [127:0] fifo[$];
  logic [127:0] m_key = '0, m_din = '0, m_state = '0;
  bit           m_ie, m_ovf, m_unf, m_kerr, m_ack, m_rd, m_irq, m_valid;
  logic [31:0]  m_dat = '0;
  int           cyc_n = 0;

  function automatic logic [31:0] m_word(input logic [127:0] v, input int w);
    return v[32*(3-w) +: 32];
  endfunction

  function automatic logic [127:0] m_put(input logic [127:0] v, input int w,
                                         input logic [31:0] d, input logic [3:0] s);
    logic [127:0] r = v;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[32*(3-w) + 8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin : model
    int w;
    bit req;
    logic [31:0] rdv;
    blk_t b;
    cyc_n++;
    m_valid = 1'b1;
    if (!rst) begin
      pend.delete(); fifo.delete();
      m_key = KRST; m_din = '0; m_state = '0; m_ie = 0;
      m_ovf = 0; m_unf = 0; m_kerr = 0;
      m_ack = 0; m_rd = 0; m_dat = '0; m_irq = 0;
    end else begin
      req = cyc && stb && !m_ack;
      w   = int'(adr[7:2]);
      rdv = '0;
      if (req && !we) begin
        if (w < 4)       rdv = m_word(m_key, w);
        else if (w < 8)  rdv = m_word(m_din, w - 4);
        else if (w < 12) begin
          if (fifo.size() == 0) m_unf = 1;
          else begin
            rdv = m_word(fifo[0], w - 8);
            if (w == 11) void'(fifo.pop_front());
          end
        end
        else if (w == 12) rdv = {29'd0, m_ie, 2'b00};
        else if (w == 13) rdv = {17'd0, m_kerr, m_unf, m_ovf, pend.size() != 0,
                                 6'(pend.size()), 5'(fifo.size())};
      end
      if (req && we) begin
        if (w < 4) begin
          if (pend.size() != 0) m_kerr = 1;
          else m_key = m_put(m_key, w, dat_i, sel);
        end
        else if (w < 8) m_din = m_put(m_din, w - 4, dat_i, sel);
        else if (w == 12) begin
          m_ie = dat_i[2];
          if (dat_i[1]) begin
            pend.delete(); fifo.delete();
          end else if (dat_i[0]) begin
            if (pend.size() + fifo.size() < DEPTH) begin
              pend.push_back('{cyc_n + LAT + 1, m_din ^ m_key});
              m_state = m_din;
            end else m_ovf = 1;
          end
        end
        else if (w == 13) begin
          if (dat_i[12]) m_ovf  = 0;
          if (dat_i[13]) m_unf  = 0;
          if (dat_i[14]) m_kerr = 0;
        end
      end
      m_ack = req;
      m_rd  = req && !we;
      m_dat = rdv;
      while (pend.size() > 0 && pend[0].due == cyc_n) begin
        b = pend.pop_front();
        fifo.push_back(b.val);
      end
      m_irq = m_ie && fifo.size() != 0;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("ack", 128'(ack), 128'(m_ack));
      chk("irq", 128'(irq), 128'(m_irq));
      chk("core_state", core_state, m_state);
      chk("core_key", core_key, m_key);
      if (m_ack && m_rd) chk("rdata", 128'(dat_o), 128'(m_dat));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic xfer(input logic [7:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] q);
    int n = 0;
    adr = a; we = w; dat_i = d; sel = s; cyc = 1; stb = 1;
    do begin @(negedge clk); n++; end while (!ack && n < 20);
    if (!ack) begin
      n_chk++;
      $display("FAIL ack_timeout: adr %h got no ack within 20 cycles", a);
    end
    q = dat_o;
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] q;
    xfer(a, 1'b1, d, 4'hf, q);
  endtask

  task automatic rd_chk(input string nm, input logic [7:0] a, input logic [31:0] e);
    logic [31:0] q;
    xfer(a, 1'b0, 32'd0, 4'hf, q);
    chk(nm, 128'(q), 128'(e));
  endtask

  initial begin
    logic [31:0] q;
    @(negedge clk);
    // WB read held during reset must not be acked until release.
    adr = 8'h34; we = 0; cyc = 1; stb = 1;
    repeat (3) begin @(negedge clk); chk("ack_in_reset", 128'(ack), 128'd0); end
    rst = 1;
    xfer(8'h34, 1'b0, 32'd0, 4'hf, q);
    chk("rst_status", 128'(q), 128'd0);
    rd_chk("key_rst_w0", 8'h00, 32'h0f0e0d0c);
    rd_chk("key_rst_w3", 8'h0c, 32'h03020100);
    rd_chk("ctrl_rst", 8'h30, 32'h0);
    xfer(8'h10, 1'b1, 32'h11223344, 4'b0101, q);
    rd_chk("din_bytesel", 8'h10, 32'h00220044);
    wr(8'h40, 32'hffffffff);
    rd_chk("unmapped", 8'h40, 32'h0);

    // Basic block
    wr(8'h00, 32'h00010203); wr(8'h04, 32'h04050607);
    wr(8'h08, 32'h08090a0b); wr(8'h0c, 32'h0c0d0e0f);
    wr(8'h10, 32'h00112233); wr(8'h14, 32'h44556677);
    wr(8'h18, 32'h8899aabb); wr(8'h1c, 32'hccddeeff);
    wr(8'h30, 32'h5);
    rd_chk("basic_busy", 8'h34, 32'h00000820);
    repeat (LAT + 2) @(negedge clk);
    rd_chk("basic_done", 8'h34, 32'h00000001);
    chk("basic_irq", 128'(irq), 128'd1);
    rd_chk("dout_w0", 8'h20, 32'h00102030);
    rd_chk("dout_w1", 8'h24, 32'h40506070);
    rd_chk("dout_w2", 8'h28, 32'h8090a0b0);
    rd_chk("dout_w3", 8'h2c, 32'hc0d0e0f0);
    rd_chk("basic_empty", 8'h34, 32'h0);

    // Underflow
    rd_chk("unf_data", 8'h2c, 32'h0);
    rd_chk("unf_status", 8'h34, 32'h00002000);
    wr(8'h34, 32'h00002000);
    rd_chk("unf_clear", 8'h34, 32'h0);

    // Full: DEPTH+1 GOs, last refused
    for (int i = 0; i <= DEPTH; i++) begin
      wr(8'h1c, 32'(i));
      wr(8'h30, 32'h5);
    end
    repeat (LAT + 12) @(negedge clk);
    rd_chk("full_status", 8'h34, 32'h00001004);
    chk("full_irq", 128'(irq), 128'd1);
    for (int i = 0; i < DEPTH; i++) rd_chk("full_order", 8'h2c, 32'h0c0d0e0f ^ 32'(i));
    wr(8'h34, 32'h00001000);
    rd_chk("full_drained", 8'h34, 32'h0);

    // Pop coincident with capture at out_count = 2
    wr(8'h1c, 32'ha); wr(8'h30, 32'h5);
    wr(8'h1c, 32'hb); wr(8'h30, 32'h5);
    repeat (LAT + 4) @(negedge clk);
    rd_chk("conc_two", 8'h34, 32'h00000002);
    wr(8'h1c, 32'hc); wr(8'h30, 32'h5);
    repeat (LAT) @(negedge clk);
    rd_chk("conc_pop_a", 8'h2c, 32'h0c0d0e0f ^ 32'ha);
    rd_chk("conc_status", 8'h34, 32'h00000002);
    rd_chk("conc_pop_b", 8'h2c, 32'h0c0d0e0f ^ 32'hb);
    rd_chk("conc_pop_c", 8'h2c, 32'h0c0d0e0f ^ 32'hc);

    // Key lock and FLUSH
    wr(8'h30, 32'h5); wr(8'h30, 32'h5); wr(8'h30, 32'h5);
    wr(8'h00, 32'hffffffff);
    rd_chk("klock_status", 8'h34, 32'h00004860);
    rd_chk("klock_key", 8'h00, 32'h00010203);
    wr(8'h30, 32'h6);
    rd_chk("flush_status", 8'h34, 32'h00004000);
    repeat (LAT + 5) @(negedge clk);
    rd_chk("flush_nocap", 8'h34, 32'h00004000);
    wr(8'h34, 32'h00004000);
    wr(8'h30, 32'h3);
    rd_chk("goflush", 8'h34, 32'h0);

    // Reset with two blocks in flight
    wr(8'h30, 32'h1); wr(8'h30, 32'h1);
    repeat (5) @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    rd_chk("rst_mid_status", 8'h34, 32'h0);
    repeat (LAT + 5) @(negedge clk);
    rd_chk("rst_nocap", 8'h34, 32'h0);
    rd_chk("rst_key", 8'h00, 32'h0f0e0d0c);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1, "watchdog");
  end
endmodule
